// File: rtl/ct_reader_pkg.sv
// Shared types and sizing for the cipher-text BRAM reader.
// Defaults describe the 128-bit AES block held one bit per address.
package ct_reader_pkg;

  localparam int CT_DATA_BITS = 128;
  localparam int CT_ADDR_W = 7;
  localparam int CT_BYTE_W = 8;

  localparam int NUM_BYTES = CT_DATA_BITS / CT_BYTE_W;
  localparam int PAIRS_PER_BYTE = CT_BYTE_W / 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    SEND,
    FIN
  } state_e;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/ct_bram_reader_if.sv
// BRAM read ports (A even / B odd) plus the byte stream to UART TX.
// master = reader side, slave = memory and UART side.
interface ct_bram_reader_if
  import ct_reader_pkg::*;
#(
  parameter int ADDR_W = CT_ADDR_W,
  parameter int BYTE_W = CT_BYTE_W
);

  logic              ena;
  logic [ADDR_W-1:0] addra;
  logic              douta;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic              doutb;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output ena,
    output addra,
    input  douta,
    output enb,
    output addrb,
    input  doutb,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  ena,
    input  addra,
    output douta,
    input  enb,
    input  addrb,
    output doutb,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/ct_byte_packer.sv
// Two-bit-per-cycle left shift register feeding a byte holding register.
// The holding register parallel-loads either the shifted byte or an external value.
module ct_byte_packer
  import ct_reader_pkg::*;
#(
  parameter int BYTE_W = CT_BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              shift,
  input  logic [1:0]        din,
  input  logic              ld,
  input  logic [BYTE_W-1:0] ld_val,
  output logic [BYTE_W-1:0] sreg_nxt,
  output logic [BYTE_W-1:0] dout
);

  logic [BYTE_W-1:0] sreg_q, sreg_d;
  logic [BYTE_W-1:0] dout_q, dout_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
      dout_q <= '0;
    end else begin
      sreg_q <= sreg_d;
      dout_q <= dout_d;
    end
  end

  always_comb begin
    sreg_nxt = {sreg_q[BYTE_W-3:0], din};
    sreg_d = sreg_q;
    dout_d = dout_q;
    if (clr) begin
      sreg_d = '0;
      dout_d = '0;
    end else begin
      if (shift) sreg_d = sreg_nxt;
      if (ld) dout_d = ld_val;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/ct_bram_reader.sv
// Reads the cipher-text BRAM two bits per cycle and streams bytes MSB-first.
// Define CT_READER_CHECKSUM_EN to append an XOR checksum byte after the data.
module ct_bram_reader
  import ct_reader_pkg::*;
#(
  parameter int DATA_BITS = CT_DATA_BITS,
  parameter int ADDR_W = CT_ADDR_W,
  parameter int BYTE_W = CT_BYTE_W,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  ct_bram_reader_if.master bus,
  output logic             busy,
  output logic             done
);

  localparam int NB = DATA_BITS / BYTE_W;
  localparam int PPB = BYTE_W / 2;
  localparam int CW = $clog2(NB + 1);
  localparam int PW = clog2_min1(PPB);
  localparam int BW = ADDR_W + 1;
`ifdef CT_READER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
  localparam int LAST = NB;
`else
  localparam bit CSUM = 1'b0;
  localparam int LAST = NB - 1;
`endif

  if (RD_LAT != 1) begin : g_rd_lat_chk
    $error("ct_bram_reader: only RD_LAT=1 is supported");
  end
  if ((2 ** ADDR_W) < DATA_BITS) begin : g_addr_chk
    $error("ct_bram_reader: ADDR_W too small for DATA_BITS");
  end
  if ((DATA_BITS % BYTE_W) != 0) begin : g_byte_chk
    $error("ct_bram_reader: DATA_BITS must be a multiple of BYTE_W");
  end

  state_e state_q, state_d;
  logic [CW-1:0] byte_q, byte_d;
  logic [PW-1:0] pair_q, pair_d;
  logic [BW-1:0] bit_q, bit_d;

  logic issue;
  logic hs;
  logic clr;
  logic last_pair;
  logic last_byte;
  logic in_rng;
  logic shift_en;
  logic ld;
  logic [BYTE_W-1:0] sreg_nxt;
  logic [BYTE_W-1:0] ld_val;
  logic [BYTE_W-1:0] tx_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      byte_q <= '0;
      pair_q <= '0;
      bit_q <= '0;
    end else begin
      state_q <= state_d;
      byte_q <= byte_d;
      pair_q <= pair_d;
      bit_q <= bit_d;
    end
  end

  assign clr = (state_q == IDLE) && start;
  assign hs = (state_q == SEND) && bus.tx_ready;
  assign last_pair = (pair_q == PW'(PPB - 1));
  assign last_byte = (byte_q == CW'(LAST));
  assign in_rng = (bit_q < BW'(DATA_BITS));
  assign issue = (state_q == FETCH) && in_rng;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = FETCH;
      FETCH: if (last_pair) state_d = DRAIN;
      DRAIN: state_d = SEND;
      SEND: begin
        if (hs) begin
          if (last_byte) state_d = FIN;
          else if (CSUM && (byte_q == CW'(NB - 1))) state_d = DRAIN;
          else state_d = FETCH;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_d = byte_q;
    pair_d = pair_q;
    bit_d = bit_q;
    if (clr) begin
      byte_d = '0;
      pair_d = '0;
      bit_d = '0;
    end else begin
      if (state_q == FETCH) begin
        pair_d = last_pair ? '0 : pair_q + 1'b1;
      end
      if (issue) bit_d = bit_q + BW'(2);
      if (hs && !last_byte) byte_d = byte_q + 1'b1;
    end
  end

  // The pair issued last cycle is on douta/doutb now; DRAIN takes the 4th.
  assign shift_en = ((state_q == FETCH) && (pair_q != '0)) ||
                    (state_q == DRAIN);
  assign ld = (state_q == DRAIN);

`ifdef CT_READER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) csum_q <= '0;
    else csum_q <= csum_d;
  end

  always_comb begin
    csum_d = csum_q;
    if (clr) csum_d = '0;
    else if (hs && (byte_q < CW'(NB))) csum_d = csum_q ^ tx_byte;
  end

  always_comb begin
    ld_val = sreg_nxt;
    if (byte_q == CW'(NB)) ld_val = csum_q;
  end
`else
  always_comb begin
    ld_val = sreg_nxt;
  end
`endif

  ct_byte_packer #(
    .BYTE_W(BYTE_W)
  ) u_packer (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .shift(shift_en),
    .din({bus.douta, bus.doutb}),
    .ld(ld),
    .ld_val(ld_val),
    .sreg_nxt(sreg_nxt),
    .dout(tx_byte)
  );

  always_comb begin
    bus.ena = issue;
    bus.enb = issue;
    bus.addra = {bit_q[ADDR_W-1:1], 1'b0};
    bus.addrb = {bit_q[ADDR_W-1:1], 1'b1};
    bus.tx_data = tx_byte;
    bus.tx_valid = (state_q == SEND);
    busy = (state_q == FETCH) || (state_q == DRAIN) || (state_q == SEND);
    done = (state_q == FIN);
  end

endmodule

// File: tb/tb_ct_bram_reader.sv
// Directed and randomised readouts against a vector-slicing reference model.
// Covers backpressure, start while busy, reset mid-readout and latency.
module tb_ct_bram_reader;
  import ct_reader_pkg::*;

  localparam int NB = NUM_BYTES;
`ifdef CT_READER_CHECKSUM_EN
  localparam int NTX = NB + 1;
`else
  localparam int NTX = NB;
`endif
  localparam logic [127:0] BASIC = 128'h3AD77BB40D7A3660A89ECAF32466EF97;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  ct_bram_reader_if #(.ADDR_W(7), .BYTE_W(8)) bus ();

  ct_bram_reader dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus.master),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  bit mem [0:127];

  always @(posedge clk) begin
    if (bus.ena) bus.douta <= mem[bus.addra];
    if (bus.enb) bus.doutb <= mem[bus.addrb];
  end

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_q [$];
  int done_cnt = 0;
  int addr_bad = 0;
  int stall_en = 0;
  int hold_bad = 0;
  int busy_bad = 0;
  logic [6:0] exp_addr = '0;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic pb = 1'b0;
  logic [7:0] pd = '0;

  always @(negedge clk) begin
    if (bus.tx_valid && bus.tx_ready) rx_q.push_back(bus.tx_data);
    if (done) done_cnt++;
    if (done && (busy || !pb)) busy_bad++;
    if (bus.ena) begin
      if (bus.addra !== exp_addr || bus.addrb !== exp_addr + 7'd1 ||
          bus.enb !== 1'b1) addr_bad++;
      exp_addr += 7'd2;
    end
    if (bus.ena && bus.tx_valid) stall_en++;
    if (pv && !pr && (bus.tx_valid !== 1'b1 || bus.tx_data !== pd)) hold_bad++;
    pv = bus.tx_valid;
    pr = bus.tx_ready;
    pd = bus.tx_data;
    pb = busy;
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [127:0] w, input int n);
    return w[127-8*n -: 8];
  endfunction

  function automatic logic [7:0] exp_csum(input logic [127:0] w);
    logic [7:0] x = '0;
    for (int n = 0; n < NB; n++) x ^= exp_byte(w, n);
    return x;
  endfunction

  task automatic load(input logic [127:0] w);
    for (int a = 0; a < 128; a++) mem[a] = w[127-a];
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ena"}, bus.ena, 1'b0);
    chk({tag, "_enb"}, bus.enb, 1'b0);
    chk({tag, "_addra"}, bus.addra, 7'd0);
    chk({tag, "_addrb"}, bus.addrb, 7'd1);
    chk({tag, "_txd"}, bus.tx_data, 8'h00);
    chk({tag, "_txv"}, bus.tx_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  task automatic readout(input string tag, input logic [127:0] w,
                         input int stall_at, input int restart_at,
                         input bit rnd, output int lat);
    int stall_left;
    bit stalled;
    bit restarted;
    bit finished;
    logic [7:0] got;
    load(w);
    rx_q.delete();
    done_cnt = 0;
    addr_bad = 0;
    stall_en = 0;
    hold_bad = 0;
    busy_bad = 0;
    exp_addr = '0;
    lat = -1;
    stall_left = 0;
    stalled = 0;
    restarted = 0;
    finished = 0;
    @(posedge clk);
    #1 start = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done_cnt != 0) begin
        finished = 1;
        break;
      end
      if (lat < 0 && bus.tx_valid) lat = cyc;
      if (restart_at >= 0 && !restarted && rx_q.size() == restart_at && busy) begin
        start = 1'b1;
        restarted = 1;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) bus.tx_ready = 1'b1;
      end else if (stall_at >= 0 && !stalled && rx_q.size() == stall_at &&
                   bus.tx_valid) begin
        bus.tx_ready = 1'b0;
        stall_left = 7;
        stalled = 1;
        chk({tag, "_stall_data"}, bus.tx_data, exp_byte(w, stall_at));
      end else if (rnd) begin
        bus.tx_ready = 1'($urandom_range(0, 1));
      end
    end
    bus.tx_ready = 1'b1;
    chk({tag, "_finished"}, finished, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_nbytes"}, rx_q.size(), NTX);
    for (int n = 0; n < NB; n++) begin
      got = 'x;
      if (n < rx_q.size()) got = rx_q[n];
      chk($sformatf("%s_byte%0d", tag, n), got, exp_byte(w, n));
    end
`ifdef CT_READER_CHECKSUM_EN
    got = 'x;
    if (NB < rx_q.size()) got = rx_q[NB];
    chk({tag, "_csum"}, got, exp_csum(w));
`endif
    chk({tag, "_addr"}, addr_bad, 0);
    chk({tag, "_busy_done"}, busy_bad, 0);
    chk({tag, "_hold"}, hold_bad, 0);
    chk({tag, "_en_stall"}, stall_en, 0);
    chk({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    int lat;
    bit hit;
    logic [127:0] w;
    reset = 1'b1;
    start = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    readout("basic", BASIC, -1, -1, 1'b0, lat);
    chk("basic_latency", lat, 6);

    readout("bp", BASIC, 3, -1, 1'b0, lat);

    readout("restart", BASIC, -1, 5, 1'b0, lat);

    load(BASIC);
    rx_q.delete();
    @(posedge clk);
    #1 start = 1'b1;
    hit = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (rx_q.size() == 9 && bus.ena) begin
        hit = 1;
        break;
      end
    end
    chk("rst_reach_byte9", hit, 1'b1);
    reset = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    @(posedge clk);
    #1 reset = 1'b0;
    readout("after_rst", BASIC, -1, -1, 1'b0, lat);

    readout("ones", {128{1'b1}}, -1, -1, 1'b0, lat);
    chk("ones_latency", lat, 6);

    for (int t = 0; t < 3; t++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      readout($sformatf("rand%0d", t), w, -1, -1, 1'b1, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
